// File: rtl/rx_bit_timer.sv
// ---------------------------------------------------------------------------
// rx_bit_timer
//
// Receive-path bit-timing controller. A start pulse launches a free-running
// clock-phase counter. One shift_strobe fires per bit period at a fixed sample
// phase. The strobes are counted within a byte, and byte_done flags the end of
// every completed byte. This continues until abort or reset.
//
// Parameters
//   CLKS_PER_BIT   clocks per bit period (2..64)
//   SAMPLE_PHASE   0-based phase within a bit at which shift_strobe fires
//                  (< CLKS_PER_BIT)
//   BITS_PER_BYTE  strobes per byte (2..16)
//
// Ports
//   clk           in   system clock, rising edge active
//   n_rst         in   asynchronous active-low reset
//   start_rcv     in   one-cycle pulse, (re)start timing a packet
//   abort         in   stop timing and return to IDLE
//   d_edge        in   line-transition pulse (phase resync, optional)
//   shift_strobe  out  one-cycle pulse at the sample point of each bit
//   byte_done     out  registered pulse in the cycle after a byte's last strobe
//   bit_index     out  strobes taken in the current byte
//   busy          out  high while in RUN
//
// Optional feature
//   RX_BIT_TIMER_RESYNC_EN  when defined, d_edge in RUN reloads phase with 0
//                           instead of incrementing it. When it is not
//                           defined, d_edge is ignored.
//
// State table
//   state | meaning
//   IDLE  | counters held at 0, waiting for start_rcv
//   RUN   | phase free-runs, strobes counted into bytes
// ---------------------------------------------------------------------------
module rx_bit_timer #(
    parameter int CLKS_PER_BIT  = 8,
    parameter int SAMPLE_PHASE  = 3,
    parameter int BITS_PER_BYTE = 8
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             start_rcv,
    input  logic                             abort,
    input  logic                             d_edge,
    output logic                             shift_strobe,
    output logic                             byte_done,
    output logic [$clog2(BITS_PER_BYTE)-1:0] bit_index,
    output logic                             busy
);

    localparam int PW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(BITS_PER_BYTE);

    localparam logic [PW-1:0] PHASE_LAST   = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PHASE_SAMPLE = PW'(SAMPLE_PHASE);
    localparam logic [BW-1:0] INDEX_LAST   = BW'(BITS_PER_BYTE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [PW-1:0] phase;
    logic          strobe_now;

    // The strobe is decoded from registered state only. This means that abort,
    // start_rcv and d_edge can never create or suppress a strobe combinationally
    // in the cycle in which they are asserted.
    assign strobe_now   = (state == RUN) && (phase == PHASE_SAMPLE);
    assign shift_strobe = strobe_now;
    assign busy         = (state == RUN);

`ifndef RX_BIT_TIMER_RESYNC_EN
    logic unused_d_edge;
    assign unused_d_edge = d_edge;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            phase     <= '0;
            bit_index <= '0;
            byte_done <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            case (state)
                IDLE: begin
                    phase     <= '0;
                    bit_index <= '0;
                    if (start_rcv && !abort) begin
                        state <= RUN;
                    end
                end

                RUN: begin
                    if (abort) begin
                        state     <= IDLE;
                        phase     <= '0;
                        bit_index <= '0;
                    end else if (start_rcv) begin
                        // A restart discards the partial byte without a byte_done.
                        phase     <= '0;
                        bit_index <= '0;
                    end else begin
`ifdef RX_BIT_TIMER_RESYNC_EN
                        if (d_edge) begin
                            phase <= '0;
                        end else
`endif
                        if (phase == PHASE_LAST) begin
                            phase <= '0;
                        end else begin
                            phase <= phase + 1'b1;
                        end

                        // A strobe in a resync cycle still counts. Only the
                        // phase is realigned.
                        if (strobe_now) begin
                            if (bit_index == INDEX_LAST) begin
                                bit_index <= '0;
                                byte_done <= 1'b1;
                            end else begin
                                bit_index <= bit_index + 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    phase     <= '0;
                    bit_index <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_bit_timer.sv
module tb_rx_bit_timer;

    logic       clk;
    logic       n_rst;
    logic       start_rcv, abort, d_edge;
    logic       shift_strobe, byte_done, busy;
    logic [2:0] bit_index;

    logic       start_c, abort_c, d_edge_c;
    logic       strobe_c, byte_done_c, busy_c;
    logic [0:0] bit_index_c;

    int checks;
    int failures;

    rx_bit_timer u_dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start_rcv    (start_rcv),
        .abort        (abort),
        .d_edge       (d_edge),
        .shift_strobe (shift_strobe),
        .byte_done    (byte_done),
        .bit_index    (bit_index),
        .busy         (busy)
    );

    rx_bit_timer #(
        .CLKS_PER_BIT  (2),
        .SAMPLE_PHASE  (1),
        .BITS_PER_BYTE (2)
    ) u_corner (
        .clk          (clk),
        .n_rst        (n_rst),
        .start_rcv    (start_c),
        .abort        (abort_c),
        .d_edge       (d_edge_c),
        .shift_strobe (strobe_c),
        .byte_done    (byte_done_c),
        .bit_index    (bit_index_c),
        .busy         (busy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #3;
        checks += 4;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (shift_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", shift_strobe); end
        if (byte_done !== 1'b0) begin failures++; $display("FAIL reset_byte_done got=%b exp=0", byte_done); end
        if (bit_index !== 3'd0) begin failures++; $display("FAIL reset_bit_index got=%0d exp=0", bit_index); end
        start_rcv = 1'b1;
        start_c   = 1'b1;
        tick;
        start_rcv = 1'b0;
        start_c   = 1'b0;
        tick;
        checks += 2;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_hold_busy got=%b exp=0", busy); end
        if (busy_c !== 1'b0) begin failures++; $display("FAIL reset_hold_busy_c got=%b exp=0", busy_c); end
        n_rst = 1'b1;
        tick;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_first_edge_busy got=%b exp=0", busy); end
    endtask

    task automatic test_basic_byte;
        int nstr;
        logic exp_s, exp_bd;
        nstr = 0;
        start_rcv = 1'b1;
        tick;
        start_rcv = 1'b0;
        for (int t = 1; t <= 76; t++) begin
            if (t > 1) tick;
            exp_s  = (t >= 4) && (((t - 4) % 8) == 0);
            exp_bd = (t == 61);
            checks += 4;
            if (shift_strobe !== exp_s) begin failures++; $display("FAIL basic_strobe t=%0d got=%b exp=%b", t, shift_strobe, exp_s); end
            if (byte_done !== exp_bd) begin failures++; $display("FAIL basic_byte_done t=%0d got=%b exp=%b", t, byte_done, exp_bd); end
            if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy t=%0d got=%b exp=1", t, busy); end
            if (bit_index !== 3'(nstr % 8)) begin failures++; $display("FAIL basic_bit_index t=%0d got=%0d exp=%0d", t, bit_index, nstr % 8); end
            if (exp_s) nstr++;
        end
        abort = 1'b1;
        tick;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL basic_abort_busy got=%b exp=0", busy); end
    endtask

    task automatic test_mid_run_reset;
        start_rcv = 1'b1;
        tick;
        start_rcv = 1'b0;
        for (int t = 2; t <= 21; t++) tick;
        #3;
        n_rst = 1'b0;
        #1;
        checks += 4;
        if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        if (shift_strobe !== 1'b0) begin failures++; $display("FAIL midrst_strobe got=%b exp=0", shift_strobe); end
        if (byte_done !== 1'b0) begin failures++; $display("FAIL midrst_byte_done got=%b exp=0", byte_done); end
        if (bit_index !== 3'd0) begin failures++; $display("FAIL midrst_bit_index got=%0d exp=0", bit_index); end
        tick;
        tick;
        n_rst = 1'b1;
        for (int t = 0; t < 20; t++) begin
            tick;
            checks += 2;
            if (shift_strobe !== 1'b0) begin failures++; $display("FAIL midrst_post_strobe t=%0d got=%b exp=0", t, shift_strobe); end
            if (busy !== 1'b0) begin failures++; $display("FAIL midrst_post_busy t=%0d got=%b exp=0", t, busy); end
        end
    endtask

    task automatic test_abort;
        start_rcv = 1'b1;
        tick;
        start_rcv = 1'b0;
        for (int t = 2; t <= 36; t++) tick;
        checks += 2;
        if (shift_strobe !== 1'b1) begin failures++; $display("FAIL abort_5th_strobe got=%b exp=1", shift_strobe); end
        if (bit_index !== 3'd4) begin failures++; $display("FAIL abort_idx_before got=%0d exp=4", bit_index); end
        abort = 1'b1;
        #1;
        checks++;
        if (shift_strobe !== 1'b1) begin failures++; $display("FAIL abort_strobe_visible got=%b exp=1", shift_strobe); end
        tick;
        abort = 1'b0;
        checks += 3;
        if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        if (shift_strobe !== 1'b0) begin failures++; $display("FAIL abort_strobe_after got=%b exp=0", shift_strobe); end
        if (bit_index !== 3'd0) begin failures++; $display("FAIL abort_idx_after got=%0d exp=0", bit_index); end
        for (int t = 0; t < 70; t++) begin
            tick;
            checks += 2;
            if (shift_strobe !== 1'b0) begin failures++; $display("FAIL abort_quiet_strobe t=%0d got=%b exp=0", t, shift_strobe); end
            if (byte_done !== 1'b0) begin failures++; $display("FAIL abort_quiet_byte_done t=%0d got=%b exp=0", t, byte_done); end
        end
        abort     = 1'b1;
        start_rcv = 1'b1;
        tick;
        abort     = 1'b0;
        start_rcv = 1'b0;
        for (int t = 0; t < 10; t++) begin
            checks += 2;
            if (busy !== 1'b0) begin failures++; $display("FAIL abort_start_idle_busy t=%0d got=%b exp=0", t, busy); end
            if (shift_strobe !== 1'b0) begin failures++; $display("FAIL abort_start_idle_strobe t=%0d got=%b exp=0", t, shift_strobe); end
            tick;
        end
    endtask

    task automatic test_restart;
        int nstr;
        logic exp_s, exp_bd;
        start_rcv = 1'b1;
        tick;
        start_rcv = 1'b0;
        for (int t = 2; t <= 21; t++) tick;
        checks++;
        if (bit_index !== 3'd3) begin failures++; $display("FAIL restart_idx_before got=%0d exp=3", bit_index); end
        start_rcv = 1'b1;
        tick;
        start_rcv = 1'b0;
        nstr = 0;
        for (int t = 1; t <= 64; t++) begin
            if (t > 1) tick;
            exp_s  = (t >= 4) && (((t - 4) % 8) == 0);
            exp_bd = (t == 61);
            checks += 3;
            if (shift_strobe !== exp_s) begin failures++; $display("FAIL restart_strobe t=%0d got=%b exp=%b", t, shift_strobe, exp_s); end
            if (byte_done !== exp_bd) begin failures++; $display("FAIL restart_byte_done t=%0d got=%b exp=%b", t, byte_done, exp_bd); end
            if (bit_index !== 3'(nstr % 8)) begin failures++; $display("FAIL restart_bit_index t=%0d got=%0d exp=%0d", t, bit_index, nstr % 8); end
            if (exp_s) nstr++;
        end
        abort = 1'b1;
        tick;
        abort = 1'b0;
    endtask

    task automatic test_param_corner;
        int nstr;
        logic exp_s, exp_bd;
        nstr = 0;
        start_c = 1'b1;
        tick;
        start_c = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            if (t > 1) tick;
            exp_s  = (t >= 2) && ((t % 2) == 0);
            exp_bd = (t >= 5) && (((t - 5) % 4) == 0);
            checks += 3;
            if (strobe_c !== exp_s) begin failures++; $display("FAIL corner_strobe t=%0d got=%b exp=%b", t, strobe_c, exp_s); end
            if (byte_done_c !== exp_bd) begin failures++; $display("FAIL corner_byte_done t=%0d got=%b exp=%b", t, byte_done_c, exp_bd); end
            if (bit_index_c !== 1'(nstr % 2)) begin failures++; $display("FAIL corner_bit_index t=%0d got=%0d exp=%0d", t, bit_index_c, nstr % 2); end
            if (exp_s) nstr++;
        end
        abort_c = 1'b1;
        tick;
        abort_c = 1'b0;
        checks++;
        if (busy_c !== 1'b0) begin failures++; $display("FAIL corner_abort_busy got=%b exp=0", busy_c); end
    endtask

    task automatic test_resync;
        int   exp_t;
        logic exp_s;
`ifdef RX_BIT_TIMER_RESYNC_EN
        exp_t = 19;
`else
        exp_t = 20;
`endif
        start_rcv = 1'b1;
        tick;
        start_rcv = 1'b0;
        for (int t = 2; t <= 15; t++) tick;
        checks++;
        if (bit_index !== 3'd2) begin failures++; $display("FAIL resync_idx_before got=%0d exp=2", bit_index); end
        d_edge = 1'b1;
        tick;
        d_edge = 1'b0;
        for (int t = 16; t <= 22; t++) begin
            if (t > 16) tick;
            exp_s = (t == exp_t);
            checks++;
            if (shift_strobe !== exp_s) begin failures++; $display("FAIL resync_strobe t=%0d got=%b exp=%b", t, shift_strobe, exp_s); end
        end
        checks++;
        if (bit_index !== 3'd3) begin failures++; $display("FAIL resync_idx_after got=%0d exp=3", bit_index); end
        abort = 1'b1;
        tick;
        abort = 1'b0;
        d_edge = 1'b1;
        tick;
        d_edge = 1'b0;
        for (int t = 0; t < 5; t++) begin
            checks += 2;
            if (busy !== 1'b0) begin failures++; $display("FAIL resync_idle_busy t=%0d got=%b exp=0", t, busy); end
            if (shift_strobe !== 1'b0) begin failures++; $display("FAIL resync_idle_strobe t=%0d got=%b exp=0", t, shift_strobe); end
            tick;
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        n_rst     = 1'b0;
        start_rcv = 1'b0;
        abort     = 1'b0;
        d_edge    = 1'b0;
        start_c   = 1'b0;
        abort_c   = 1'b0;
        d_edge_c  = 1'b0;

        test_reset;
        test_basic_byte;
        test_mid_run_reset;
        test_abort;
        test_restart;
        test_param_corner;
        test_resync;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
